sub_8bit_serial: RTL and testbench

SUB_8BIT_SERIAL -- requirements
Module: sub_8bit_serial

---
 rtl/sub_8bit_serial.sv | 106 ++++++++++
 tb/tb_sub_8bit_serial.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_8bit_serial.sv
// Bit-serial unsigned subtractor: one result bit per clock, LSB first, with
// valid/ready handshakes on the operand and result sides.
module sub_8bit_serial #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             busy
);

   localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] a_q, b_q, acc, acc_next;
   logic [CW-1:0]    cnt;
   logic             br, br_next, d_bit, bit_a, bit_b;
   logic             ready_en, accept, last_bit;

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept)    state_next = RUN;
         RUN:     if (last_bit)  state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   // ---------------- outputs ----------------
   always_comb begin
      in_ready  = ready_en && (state == IDLE);
      out_valid = (state == DONE);
      busy      = (state != IDLE);
   end

   assign accept   = in_valid && in_ready;
   assign last_bit = (cnt == CW'(WIDTH - 1));

   // Full-subtractor cell applied to the current bit position.
   always_comb begin
      bit_a    = a_q[cnt];
      bit_b    = b_q[cnt];
      d_bit    = bit_a ^ bit_b ^ br;
      br_next  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br);
      acc_next = acc;
      acc_next[cnt] = d_bit;
   end

   // Stays low until the first edge after reset release, holding off acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ready_en <= 1'b0;
      else        ready_en <= 1'b1;
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         acc    <= '0;
         cnt    <= '0;
         br     <= 1'b0;
         diff   <= '0;
         borrow <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               a_q <= a;
               b_q <= b;
               acc <= '0;
               cnt <= '0;
               br  <= 1'b0;
            end
            RUN: begin
               acc <= acc_next;
               br  <= br_next;
               cnt <= cnt + CW'(1);
               // Published result changes only on DONE entry.
               if (last_bit) begin
                  diff   <= acc_next;
                  borrow <= br_next;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sub_8bit_serial.sv
// Directed and random self-checking bench for sub_8bit_serial (WIDTH=8).
module tb_sub_8bit_serial;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a, b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] diff;
   logic       borrow;
   logic       busy;

   int checks = 0;
   int errors = 0;

   sub_8bit_serial #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .borrow(borrow), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one handshake; caller has already seen in_ready high.
   task automatic accept(input logic [7:0] av, input logic [7:0] bv);
      in_valid = 1'b1;
      a        = av;
      b        = bv;
      tick();
      in_valid = 1'b0;
   endtask

   // Counts edges until out_valid; returns 30 on timeout.
   task automatic wait_out(input bit noise, output int n);
      n = 30;
      for (int i = 1; i <= 30; i++) begin
         if (noise) begin
            in_valid = 1'($urandom_range(0, 1));
            a        = 8'($urandom);
            b        = 8'($urandom);
         end
         tick();
         if (out_valid === 1'b1) begin
            n = i;
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      tick(); tick();
      checks++;
      if ({in_ready, out_valid, busy, borrow, diff} !== 12'h000) begin
         errors++;
         $display("FAIL reset_outputs: got in_ready=%b out_valid=%b busy=%b borrow=%b diff=%h, expected all 0",
                  in_ready, out_valid, busy, borrow, diff);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_before_edge: got %b, expected 0", in_ready);
      end
      tick();
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL ready_after_release: got in_ready=%b busy=%b, expected 1/0", in_ready, busy);
      end
   endtask

   task automatic test_basic();
      int n;
      out_ready = 1'b1;
      accept(8'h05, 8'h03);
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_run_flags: got busy=%b in_ready=%b out_valid=%b, expected 1/0/0",
                  busy, in_ready, out_valid);
      end
      wait_out(1'b0, n);
      checks++;
      if (n !== 8) begin
         errors++;
         $display("FAIL basic_latency: got %0d edges, expected 8", n);
      end
      checks++;
      if (diff !== 8'h02 || borrow !== 1'b0) begin
         errors++;
         $display("FAIL basic_result: got diff=%h borrow=%b, expected 02/0", diff, borrow);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_idle: got out_valid=%b busy=%b in_ready=%b, expected 0/0/1",
                  out_valid, busy, in_ready);
      end
   endtask

   task automatic test_underflow();
      logic [7:0] va [3] = '{8'h00, 8'h80, 8'hFF};
      logic [7:0] vb [3] = '{8'h01, 8'h80, 8'h00};
      logic [7:0] ed [3] = '{8'hFF, 8'h00, 8'hFF};
      logic       eb [3] = '{1'b1, 1'b0, 1'b0};
      int n;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         accept(va[i], vb[i]);
         wait_out(1'b0, n);
         checks++;
         if (n !== 8 || diff !== ed[i] || borrow !== eb[i]) begin
            errors++;
            $display("FAIL underflow_%0d: got lat=%0d diff=%h borrow=%b, expected 8/%h/%b",
                     i, n, diff, borrow, ed[i], eb[i]);
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      int n;
      out_ready = 1'b0;
      accept(8'h10, 8'h20);
      wait_out(1'b0, n);
      checks++;
      if (n !== 8) begin
         errors++;
         $display("FAIL bp_latency: got %0d edges, expected 8", n);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (out_valid !== 1'b1 || diff !== 8'hF0 || borrow !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold_%0d: got out_valid=%b diff=%h borrow=%b, expected 1/f0/1",
                     i, out_valid, diff, borrow);
         end
         tick();
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: got out_valid=%b busy=%b, expected 0/0", out_valid, busy);
      end
   endtask

   task automatic test_input_ignored();
      int n;
      out_ready = 1'b1;
      accept(8'h09, 8'h04);
      in_valid = 1'b1; a = 8'hAA; b = 8'h55;
      n = 30;
      for (int i = 1; i <= 30; i++) begin
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ignored_ready_%0d: got in_ready=%b, expected 0", i, in_ready);
         end
         tick();
         if (out_valid === 1'b1) begin
            n = i;
            break;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (n !== 8 || diff !== 8'h05 || borrow !== 1'b0) begin
         errors++;
         $display("FAIL ignored_result: got lat=%0d diff=%h borrow=%b, expected 8/05/0", n, diff, borrow);
      end
      tick();
      tick();
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL ignored_no_extra: got busy=%b out_valid=%b, expected 0/0", busy, out_valid);
      end
   endtask

   task automatic test_reset_mid_op();
      int n;
      out_ready = 1'b1;
      accept(8'h77, 8'h11);
      for (int i = 0; i < 4; i++) tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, busy, borrow, diff} !== 12'h000) begin
         errors++;
         $display("FAIL midop_async: got in_ready=%b out_valid=%b busy=%b borrow=%b diff=%h, expected all 0",
                  in_ready, out_valid, busy, borrow, diff);
      end
      tick(); tick();
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midop_no_result_%0d: got out_valid=%b busy=%b, expected 0/0", i, out_valid, busy);
         end
      end
      accept(8'h03, 8'h07);
      wait_out(1'b0, n);
      checks++;
      if (n !== 8 || diff !== 8'hFC || borrow !== 1'b1) begin
         errors++;
         $display("FAIL midop_next: got lat=%0d diff=%h borrow=%b, expected 8/fc/1", n, diff, borrow);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int t_first, t_second, cyc;
      logic prev;
      t_first = -1; t_second = -1; prev = 1'b0;
      out_ready = 1'b1; in_valid = 1'b1; a = 8'h33; b = 8'h11;
      for (cyc = 1; cyc <= 40; cyc++) begin
         tick();
         if (out_valid === 1'b1 && prev === 1'b0) begin
            if (t_first < 0) t_first = cyc;
            else begin
               t_second = cyc;
               break;
            end
         end
         prev = out_valid;
      end
      in_valid = 1'b0;
      checks++;
      if (t_first !== 9 || t_second - t_first !== 10) begin
         errors++;
         $display("FAIL b2b_timing: got first=%0d period=%0d, expected 9/10", t_first, t_second - t_first);
      end
      checks++;
      if (diff !== 8'h22 || borrow !== 1'b0) begin
         errors++;
         $display("FAIL b2b_result: got diff=%h borrow=%b, expected 22/0", diff, borrow);
      end
      tick();
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle: got busy=%b, expected 0", busy);
      end
   endtask

   task automatic test_random();
      logic [7:0] ra, rb, ed;
      logic       eb;
      int n, stall;
      for (int k = 0; k < 1500; k++) begin
         ra = 8'($urandom); rb = 8'($urandom);
         ed = ra - rb;
         eb = (ra < rb);
         for (int d = $urandom_range(0, 2); d > 0; d--) tick();
         out_ready = 1'b0;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rnd_ready_%0d: got in_ready=%b, expected 1", k, in_ready);
         end
         accept(ra, rb);
         wait_out(1'b1, n);
         checks++;
         if (n !== 8 || diff !== ed || borrow !== eb) begin
            errors++;
            $display("FAIL rnd_%0d a=%h b=%h: got lat=%0d diff=%h borrow=%b, expected 8/%h/%b",
                     k, ra, rb, n, diff, borrow, ed, eb);
         end
         stall = $urandom_range(0, 3);
         for (int s = 0; s < stall; s++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || diff !== ed || borrow !== eb) begin
               errors++;
               $display("FAIL rnd_hold_%0d: got out_valid=%b diff=%h borrow=%b, expected 1/%h/%b",
                        k, out_valid, diff, borrow, ed, eb);
            end
         end
         out_ready = 1'b1;
         tick();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rnd_drain_%0d: got out_valid=%b, expected 0", k, out_valid);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_underflow();
      test_backpressure();
      test_input_ignored();
      test_reset_mid_op();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
